// File: rtl/uart_block_link.sv
// Per-channel UART byte-to-block assembler plus a block-to-byte transmit sequencer.
// The RX and TX paths share only the clock and reset.
module uart_block_link #(
  parameter int BLOCK_BYTES = 16,
  parameter int NCH         = 2,
  parameter int CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic [CHW-1:0]                rx_ch,
  input  logic                          clr,
  output logic [NCH*BLOCK_BYTES*8-1:0]  blk_out,
  output logic [NCH-1:0]                blk_valid,
  input  logic [NCH-1:0]                blk_ack,
  output logic [NCH-1:0]                ovf,
  input  logic [BLOCK_BYTES*8-1:0]      tx_block,
  input  logic                          tx_go,
  output logic [7:0]                    tx_data,
  output logic                          tx_start,
  input  logic                          tx_done,
  output logic                          tx_busy,
  output logic                          tx_last
);
  localparam int BW   = BLOCK_BYTES * 8;
  localparam int CNTW = $clog2(BLOCK_BYTES);
  localparam logic [CNTW-1:0] LAST = CNTW'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} tx_state_t;

  logic [BW-1:0]   rx_sr  [NCH];
  logic [CNTW-1:0] rx_cnt [NCH];
  tx_state_t       state;
  logic [BW-1:0]   tx_sr;
  logic [CNTW-1:0] tx_idx;

  // An ack in the same cycle frees the channel, so a coinciding byte starts the next block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        rx_sr[c]  <= '0;
        rx_cnt[c] <= '0;
      end
      blk_valid <= '0;
      ovf       <= '0;
    end else if (clr) begin
      for (int c = 0; c < NCH; c++) rx_cnt[c] <= '0;
      blk_valid <= '0;
      ovf       <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (rx_valid && int'(rx_ch) == c && (!blk_valid[c] || blk_ack[c])) begin
          rx_sr[c]     <= {rx_sr[c][BW-9:0], rx_data};
          rx_cnt[c]    <= (rx_cnt[c] == LAST) ? '0 : rx_cnt[c] + CNTW'(1);
          blk_valid[c] <= (rx_cnt[c] == LAST);
        end else begin
          if (blk_ack[c]) blk_valid[c] <= 1'b0;
          if (rx_valid && int'(rx_ch) == c) ovf[c] <= 1'b1;
        end
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_slice
    assign blk_out[c*BW +: BW] = rx_sr[c];
  end

  // Entry from IDLE pulses tx_start immediately; entry from WAIT spends one SEND
  // cycle loading the byte, so the pulse lands two cycles after tx_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_sr    <= '0;
      tx_idx   <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      tx_busy  <= 1'b0;
      tx_last  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      tx_last  <= 1'b0;
      case (state)
        IDLE: if (tx_go) begin
          tx_sr    <= tx_block;
          tx_idx   <= '0;
          tx_data  <= tx_block[BW-1 -: 8];
          tx_start <= 1'b1;
          tx_busy  <= 1'b1;
          state    <= SEND;
        end
        SEND: if (tx_start) begin
          state <= WAIT;
        end else begin
          tx_start <= 1'b1;
          tx_data  <= tx_sr[BW-1 -: 8];
        end
        WAIT: if (tx_done) begin
          tx_sr  <= tx_sr << 8;
          tx_idx <= tx_idx + CNTW'(1);
          if (tx_idx == LAST) begin
            tx_last <= 1'b1;
            state   <= DONE;
          end else begin
            state <= SEND;
          end
        end
        DONE: begin
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_block_link.sv
// Directed bench for uart_block_link: default 16-byte/2-channel instance plus a
// 4-byte/1-channel instance, with hand-computed expected blocks and TX bytes.
module tb_uart_block_link;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ch;
  logic         clr;
  logic [255:0] blk_out;
  logic [1:0]   blk_valid;
  logic [1:0]   blk_ack;
  logic [1:0]   ovf;
  logic [127:0] tx_block;
  logic         tx_go;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_done;
  logic         tx_busy;
  logic         tx_last;

  logic [7:0]   s_rx_data;
  logic         s_rx_valid;
  logic         s_rx_ch;
  logic         s_clr;
  logic [31:0]  s_blk_out;
  logic [0:0]   s_blk_valid;
  logic [0:0]   s_blk_ack;
  logic [0:0]   s_ovf;
  logic [31:0]  s_tx_block;
  logic         s_tx_go;
  logic [7:0]   s_tx_data;
  logic         s_tx_start;
  logic         s_tx_done;
  logic         s_tx_busy;
  logic         s_tx_last;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_tx [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                              8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00};

  uart_block_link dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ch(rx_ch),
    .clr(clr), .blk_out(blk_out), .blk_valid(blk_valid), .blk_ack(blk_ack), .ovf(ovf),
    .tx_block(tx_block), .tx_go(tx_go), .tx_data(tx_data), .tx_start(tx_start),
    .tx_done(tx_done), .tx_busy(tx_busy), .tx_last(tx_last)
  );

  uart_block_link #(.BLOCK_BYTES(4), .NCH(1)) u_small (
    .clk(clk), .rst_n(rst_n), .rx_data(s_rx_data), .rx_valid(s_rx_valid), .rx_ch(s_rx_ch),
    .clr(s_clr), .blk_out(s_blk_out), .blk_valid(s_blk_valid), .blk_ack(s_blk_ack), .ovf(s_ovf),
    .tx_block(s_tx_block), .tx_go(s_tx_go), .tx_data(s_tx_data), .tx_start(s_tx_start),
    .tx_done(s_tx_done), .tx_busy(s_tx_busy), .tx_last(s_tx_last)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic ch, input logic [7:0] d,
                               input logic [1:0] ack, input logic c);
    rx_valid = v;
    rx_ch    = ch;
    rx_data  = d;
    blk_ack  = ack;
    clr      = c;
    tick;
    rx_valid = 1'b0;
    blk_ack  = 2'b00;
    clr      = 1'b0;
  endtask

  task automatic smallByte(input logic ch, input logic [7:0] d);
    s_rx_valid = 1'b1;
    s_rx_ch    = ch;
    s_rx_data  = d;
    tick;
    s_rx_valid = 1'b0;
  endtask

  // Services nbytes of a transmission, answering each tx_start with tx_done three cycles later.
  task automatic sendBlock(input int nbytes);
    tx_go = 1'b1;
    tick;
    tx_go = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      checkOutput($sformatf("tx_start_%0d", i), tx_start, 1'b1);
      checkOutput($sformatf("tx_data_%0d", i), tx_data, exp_tx[i]);
      if (i == 2) tx_go = 1'b1;
      if (i == 4) tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      checkOutput($sformatf("tx_hold_%0d", i), {tx_start, tx_data}, {1'b0, exp_tx[i]});
      checkOutput($sformatf("tx_busy_%0d", i), tx_busy, 1'b1);
      tick;
      tx_go = 1'b0;
      tick;
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
      if (i == 15) begin
        checkOutput("tx_last_pulse", {tx_last, tx_start}, 2'b10);
        tick;
        checkOutput("tx_last_end", {tx_last, tx_busy, tx_start}, 3'b000);
      end else begin
        checkOutput($sformatf("tx_gap_%0d", i), {tx_start, tx_data}, {1'b0, exp_tx[i]});
        if (i < nbytes - 1) tick;
      end
    end
  endtask

  initial begin
    int starts;
    rst_n = 1'b0;
    rx_valid = 1'b0; rx_ch = 1'b0; rx_data = '0; clr = 1'b0; blk_ack = '0;
    tx_block = 128'h112233445566778899AABBCCDDEEFF00; tx_go = 1'b0; tx_done = 1'b0;
    s_rx_valid = 1'b0; s_rx_ch = 1'b0; s_rx_data = '0; s_clr = 1'b0; s_blk_ack = '0;
    s_tx_block = '0; s_tx_go = 1'b0; s_tx_done = 1'b0;
    tick;
    tick;
    checkOutput("rst_blk_out", blk_out, '0);
    checkOutput("rst_flags", {blk_valid, ovf}, 4'b0000);
    checkOutput("rst_tx", {tx_start, tx_busy, tx_last, tx_data}, '0);
    checkOutput("rst_small", {s_blk_valid, s_ovf, s_blk_out}, '0);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 8'(i), 2'b00, 1'b0);
    checkOutput("valid_after_15", blk_valid, 2'b00);
    applyStimulus(1'b1, 1'b0, 8'h0F, 2'b00, 1'b0);
    checkOutput("valid_after_16", blk_valid, 2'b01);
    checkOutput("ch0_block", blk_out[127:0], 128'h000102030405060708090A0B0C0D0E0F);
    checkOutput("ch1_untouched", blk_out[255:128], '0);

    applyStimulus(1'b0, 1'b0, 8'h00, 2'b01, 1'b0);
    checkOutput("ack_clears", blk_valid, 2'b00);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 8'hA0 + 8'(i), 2'b00, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'h20 + 8'(i), 2'b00, 1'b0);
    end
    checkOutput("both_valid", blk_valid, 2'b11);
    checkOutput("interleave_blocks", blk_out,
                {128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 128'h202122232425262728292A2B2C2D2E2F});

    applyStimulus(1'b1, 1'b0, 8'hFF, 2'b00, 1'b0);
    checkOutput("ovf_set", ovf, 2'b01);
    checkOutput("ovf_block_kept", blk_out[127:0], 128'h202122232425262728292A2B2C2D2E2F);
    applyStimulus(1'b1, 1'b0, 8'h55, 2'b01, 1'b0);
    checkOutput("ack_with_byte_valid", {blk_valid, ovf}, 4'b1001);
    checkOutput("ack_with_byte_data", blk_out[127:0], 128'h2122232425262728292A2B2C2D2E2F55);
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0, 8'h60 + 8'(i), 2'b00, 1'b0);
    checkOutput("count_from_one", blk_valid, 2'b10);
    applyStimulus(1'b1, 1'b0, 8'h6E, 2'b00, 1'b0);
    checkOutput("second_block_valid", blk_valid, 2'b11);
    checkOutput("second_block_data", blk_out[127:0], 128'h55606162636465666768696A6B6C6D6E);

    applyStimulus(1'b1, 1'b0, 8'h99, 2'b00, 1'b1);
    checkOutput("clr_flags", {blk_valid, ovf}, 4'b0000);
    checkOutput("clr_keeps_data", blk_out,
                {128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 128'h55606162636465666768696A6B6C6D6E});

    smallByte(1'b0, 8'h01);
    smallByte(1'b0, 8'h02);
    smallByte(1'b1, 8'h99);
    smallByte(1'b0, 8'h03);
    checkOutput("small_bad_ch_dropped", {s_blk_valid, s_ovf}, 2'b00);
    smallByte(1'b0, 8'h04);
    checkOutput("small_block", {s_blk_valid, s_ovf, s_blk_out}, {2'b10, 32'h01020304});
    smallByte(1'b1, 8'hAA);
    checkOutput("small_bad_ch_silent", s_ovf, 1'b0);
    smallByte(1'b0, 8'hBB);
    checkOutput("small_ovf", {s_ovf, s_blk_out}, {1'b1, 32'h01020304});

    sendBlock(16);
    sendBlock(5);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_tx_reset_tx", {tx_start, tx_busy, tx_last, tx_data}, '0);
    checkOutput("mid_tx_reset_rx", {blk_valid, ovf, blk_out}, '0);
    tick;
    rst_n = 1'b1;
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (tx_start) starts++;
    end
    checkOutput("no_start_after_reset", starts, 0);
    checkOutput("idle_after_reset", tx_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
